// File: rtl/useq_stack_sequencer.sv
// Microcode address sequencer with a call/return stack, stall input and u_flags register.
// Optional build macro USEQ_STACK_ERR_TRAP_EN: stack overflow/underflow jumps to ERR_ADDR instead of recovering.
module useq_stack_sequencer #(
    parameter int UADDR_W        = 14,
    parameter int OFFSET_W       = 7,
    parameter int IR_W           = 8,
    parameter int DISPATCH_SHIFT = 0,
    parameter int STACK_DEPTH    = 4,
    parameter logic [UADDR_W-1:0] FETCH_ADDR = 'h010,
    parameter logic [UADDR_W-1:0] TRAP_ADDR  = 'h020,
    parameter logic [UADDR_W-1:0] ERR_ADDR   = 'h030,
    localparam int LVL_W = $clog2(STACK_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                hold,
    input  logic [2:0]          ctrl_typ,
    input  logic [OFFSET_W-1:0] ctrl_offset,
    input  logic [3:0]          cond_sel,
    input  logic                cond_invert,
    input  logic                cond_flag_src,
    input  logic [1:0]          u_zf_src,
    input  logic [1:0]          u_cf_src,
    input  logic                u_sf_src,
    input  logic                u_of_src,
    input  logic [IR_W-1:0]     ir,
    input  logic [3:0]          alu_flags,
    input  logic [7:0]          alu_out,
    input  logic [7:0]          z_bus,
    input  logic                alu_of,
    input  logic                alu_final_cf,
    input  logic [7:0]          cpu_status,
    input  logic                dma_req,
    input  logic                int_pending,
    input  logic                wait_n,
    input  logic                ext_input,
    output logic [UADDR_W-1:0]  u_address,
    output logic [3:0]          u_flags,
    output logic [LVL_W-1:0]    stack_level,
    output logic                stack_err
);

    localparam logic [UADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [LVL_W-1:0]   LVL_ONE  = 1;
    localparam logic [LVL_W-1:0]   LVL_FULL = LVL_W'(STACK_DEPTH);

    logic [UADDR_W-1:0] u_address_q, u_address_d;
    logic [3:0]         u_flags_q, u_flags_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               err_q, err_d;
    logic [UADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [UADDR_W-1:0] stack_d [STACK_DEPTH];

    logic [3:0]         flags_sel;
    logic               cond_mux, cond;
    logic [UADDR_W-1:0] off, addr_inc, addr_tgt, addr_disp;
    logic               stk_full, stk_empty;
    logic               unused_bits;

    assign unused_bits = ^{cpu_status[7:3], alu_out[6:1], z_bus[6:0]};

    assign off       = {{(UADDR_W-OFFSET_W){ctrl_offset[OFFSET_W-1]}}, ctrl_offset};
    assign addr_inc  = u_address_q + ADDR_ONE;
    assign addr_tgt  = u_address_q + off;
    assign addr_disp = UADDR_W'(ir) << DISPATCH_SHIFT;
    assign stk_full  = (level_q == LVL_FULL);
    assign stk_empty = (level_q == '0);

    // flags_sel bit order is {OF, SF, CF, ZF}
    always_comb begin
        flags_sel = cond_flag_src ? u_flags_q : alu_flags;
        cond_mux  = 1'b0;
        case (cond_sel)
            4'h0: cond_mux = flags_sel[0];
            4'h1: cond_mux = flags_sel[1];
            4'h2: cond_mux = flags_sel[2];
            4'h3: cond_mux = flags_sel[3];
            4'h4: cond_mux = flags_sel[2] ^ flags_sel[3];
            4'h5: cond_mux = (flags_sel[2] ^ flags_sel[3]) | flags_sel[0];
            4'h6: cond_mux = flags_sel[1] | flags_sel[0];
            4'h7: cond_mux = dma_req;
            4'h8: cond_mux = cpu_status[0];
            4'h9: cond_mux = wait_n;
            4'hA: cond_mux = int_pending;
            4'hB: cond_mux = ext_input;
            4'hC: cond_mux = cpu_status[1];
            4'hD: cond_mux = cpu_status[2];
            default: cond_mux = 1'b0;
        endcase
        cond = cond_mux ^ cond_invert;
    end

    always_comb begin
        u_flags_d = u_flags_q;
        case (u_zf_src)
            2'b01:   u_flags_d[0] = alu_flags[0];
            2'b10:   u_flags_d[0] = alu_flags[0] & u_flags_q[0];
            default: u_flags_d[0] = u_flags_q[0];
        endcase
        case (u_cf_src)
            2'b01:   u_flags_d[1] = alu_final_cf;
            2'b10:   u_flags_d[1] = alu_out[0];
            2'b11:   u_flags_d[1] = alu_out[7];
            default: u_flags_d[1] = u_flags_q[1];
        endcase
        if (u_sf_src) u_flags_d[2] = z_bus[7];
        if (u_of_src) u_flags_d[3] = alu_of;
    end

    // Stack is a shift register with the top at index 0, so an overflowing push drops the oldest entry.
    always_comb begin
        u_address_d = addr_tgt;
        level_d     = level_q;
        err_d       = err_q;
        for (int i = 0; i < STACK_DEPTH; i++) stack_d[i] = stack_q[i];
        case (ctrl_typ)
            3'b001: u_address_d = cond ? addr_tgt : addr_inc;
            3'b010: u_address_d = (dma_req | int_pending) ? TRAP_ADDR : FETCH_ADDR;
            3'b011: u_address_d = addr_disp;
            3'b100: begin
                if (stk_full) err_d = 1'b1;
`ifdef USEQ_STACK_ERR_TRAP_EN
                if (stk_full) begin
                    u_address_d = ERR_ADDR;
                end else
`endif
                begin
                    for (int i = 1; i < STACK_DEPTH; i++) stack_d[i] = stack_q[i-1];
                    stack_d[0]  = addr_inc;
                    u_address_d = addr_tgt;
                    if (!stk_full) level_d = level_q + LVL_ONE;
                end
            end
            3'b101: begin
                if (stk_empty) begin
                    err_d = 1'b1;
`ifdef USEQ_STACK_ERR_TRAP_EN
                    u_address_d = ERR_ADDR;
`else
                    u_address_d = FETCH_ADDR;
`endif
                end else begin
                    u_address_d = stack_q[0];
                    for (int i = 0; i < STACK_DEPTH-1; i++) stack_d[i] = stack_q[i+1];
                    stack_d[STACK_DEPTH-1] = '0;
                    level_d = level_q - LVL_ONE;
                end
            end
            default: u_address_d = addr_tgt;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            u_address_q <= '0;
            u_flags_q   <= '0;
            level_q     <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else if (!hold) begin
            u_address_q <= u_address_d;
            u_flags_q   <= u_flags_d;
            level_q     <= level_d;
            err_q       <= err_d;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

    assign u_address   = u_address_q;
    assign u_flags     = u_flags_q;
    assign stack_level = level_q;
    assign stack_err   = err_q;

endmodule
